// File: rtl/fishingrod_pkg.sv
// Shared types and helpers for the Fishingrod serial engine: FSM states,
// GF(2^w) reduction polynomials, clog2 and the nibble-parallel S-boxes.
package fishingrod_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Doubling reduction polynomial (low bits, x^w term implied) per lane width
  localparam logic [15:0] RED_POLY_TBL [3] = '{16'h0003, 16'h001B, 16'h002B};

  function automatic logic [15:0] red_poly(input int w);
    logic [15:0] p;
    case (w)
      4:       p = RED_POLY_TBL[0];
      8:       p = RED_POLY_TBL[1];
      16:      p = RED_POLY_TBL[2];
      default: p = 16'h0000;
    endcase
    return p;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] r;
    case (x)
      4'h0: r = 4'hC;  4'h1: r = 4'h5;  4'h2: r = 4'h6;  4'h3: r = 4'hB;
      4'h4: r = 4'h9;  4'h5: r = 4'h0;  4'h6: r = 4'hA;  4'h7: r = 4'hD;
      4'h8: r = 4'h3;  4'h9: r = 4'hE;  4'hA: r = 4'hF;  4'hB: r = 4'h8;
      4'hC: r = 4'h4;  4'hD: r = 4'h7;  4'hE: r = 4'h1;  default: r = 4'h2;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sbox8(input logic [7:0] x);
    return {sbox4(x[7:4]), sbox4(x[3:0])};
  endfunction

  function automatic logic [15:0] sbox16(input logic [15:0] x);
    return {sbox8(x[15:8]), sbox8(x[7:0])};
  endfunction

endpackage

// File: rtl/fishingrod_lane_step.sv
// One combinational datapath step: mixes state lane 0 with the (round-constant
// adjusted) key lane 0 and produces the new tail lanes for state and key.
module fishingrod_lane_step
  import fishingrod_pkg::*;
#(
  parameter int LANE_W = 8
) (
  input  logic [LANE_W-1:0] s0,
  input  logic [LANE_W-1:0] s1,
  input  logic [LANE_W-1:0] k0,
  input  logic [LANE_W-1:0] k1,
  input  logic [LANE_W-1:0] rc,
  input  logic              rc_en,
  input  logic              sbox_sel,
  input  logic              key_upd,
  output logic [LANE_W-1:0] lane_nxt,
  output logic [LANE_W-1:0] key_nxt
);

  localparam logic [LANE_W-1:0] POLY = LANE_W'(red_poly(LANE_W));

  logic [LANE_W-1:0] kx, mix, sb_mix, sb_key;

  function automatic logic [LANE_W-1:0] xtime(input logic [LANE_W-1:0] x);
    return {x[LANE_W-2:0], 1'b0} ^ (x[LANE_W-1] ? POLY : '0);
  endfunction

  assign kx  = k0 ^ (rc_en ? rc : '0);
  assign mix = s0 ^ kx;

  if (LANE_W == 16) begin : g_sb16
    assign sb_mix = sbox16(mix);
    assign sb_key = sbox16(kx);
  end else if (LANE_W == 8) begin : g_sb8
    assign sb_mix = sbox8(mix);
    assign sb_key = sbox8(kx);
  end else begin : g_sb4
    assign sb_mix = sbox4(mix);
    assign sb_key = sbox4(kx);
  end

  always_comb begin
    lane_nxt = sbox_sel ? sb_mix : (mix ^ xtime(s1));
    key_nxt  = key_upd ? (sb_key ^ k1) : kx;
  end

endmodule

// File: rtl/fishingrod_serial_engine.sv
// Self-sequenced lane-serial Fishingrod round engine: LOAD a block, RUN all
// rounds one lane per cycle, DRAIN the result. Optional FISHINGROD_KEY_HOLD_EN.
module fishingrod_serial_engine
  import fishingrod_pkg::*;
#(
  parameter int LANE_W      = 8,
  parameter int STATE_LANES = 12,
  parameter int KEY_LANES   = 8,
  parameter int NUM_ROUNDS  = 25
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LANE_W-1:0] in_data,
  input  logic [LANE_W-1:0] in_key,
  input  logic              in_last,
`ifdef FISHINGROD_KEY_HOLD_EN
  input  logic              key_reuse,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam int CW = clog2(STATE_LANES);
  localparam int S1 = (STATE_LANES > 1) ? 1 : 0;
  localparam int K1 = (KEY_LANES > 1) ? 1 : 0;
  localparam logic [CW-1:0] LAST_LANE = CW'(STATE_LANES - 1);
  localparam logic [CW-1:0] KUPD_STEP = CW'(KEY_LANES / 2);

  state_e            state_q, state_d;
  logic [CW-1:0]     beat_cnt, step_cnt, beat_idx;
  logic [4:0]        round_cnt;
  logic [LANE_W-1:0] st [STATE_LANES];
  logic [LANE_W-1:0] ky [KEY_LANES];
  logic              err_q;
  logic              in_hs, final_beat, load_done, load_err, run_last;
  logic [LANE_W-1:0] rc, lane_nxt, key_nxt;
  logic              reuse_now;

`ifdef FISHINGROD_KEY_HOLD_EN
  logic              reuse_q;
  logic [LANE_W-1:0] shadow [KEY_LANES];
  assign reuse_now = (state_q == IDLE) ? key_reuse : reuse_q;
`else
  assign reuse_now = 1'b0;
`endif

  assign in_ready   = !rst && ((state_q == IDLE) || (state_q == LOAD));
  assign in_hs      = in_valid && in_ready;
  // Beat 0 is taken in IDLE, where beat_cnt is not yet meaningful
  assign beat_idx   = (state_q == IDLE) ? '0 : beat_cnt;
  assign final_beat = (beat_idx == LAST_LANE);
  assign load_done  = in_hs && final_beat && in_last;
  assign load_err   = in_hs && (final_beat != in_last);
  assign run_last   = (state_q == RUN) && (step_cnt == LAST_LANE) &&
                      (round_cnt == 5'(NUM_ROUNDS));
  assign rc         = LANE_W'(round_cnt);

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DRAIN);
  assign out_last  = (state_q == DRAIN) && (beat_cnt == LAST_LANE);
  assign out_data  = (state_q == DRAIN) ? st[beat_cnt] : '0;
  assign err       = err_q;

  fishingrod_lane_step #(.LANE_W(LANE_W)) u_step (
    .s0       (st[0]),
    .s1       (st[S1]),
    .k0       (ky[0]),
    .k1       (ky[K1]),
    .rc       (rc),
    .rc_en    (step_cnt == '0),
    .sbox_sel (step_cnt == LAST_LANE),
    .key_upd  (step_cnt == KUPD_STEP),
    .lane_nxt (lane_nxt),
    .key_nxt  (key_nxt)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOAD: begin
        if (load_err)       state_d = IDLE;
        else if (load_done) state_d = RUN;
        else if (in_hs)     state_d = LOAD;
      end
      RUN:     if (run_last) state_d = DRAIN;
      DRAIN:   if (out_ready && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      step_cnt  <= '0;
      round_cnt <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < STATE_LANES; i++) st[i] <= '0;
      for (int k = 0; k < KEY_LANES; k++)   ky[k] <= '0;
`ifdef FISHINGROD_KEY_HOLD_EN
      reuse_q <= 1'b0;
      for (int k = 0; k < KEY_LANES; k++) shadow[k] <= '0;
`endif
    end else begin
      if (load_err) err_q <= 1'b1;
      case (state_q)
        IDLE, LOAD: begin
          if (in_hs) begin
            for (int i = 0; i < STATE_LANES; i++)
              if (beat_idx == CW'(i)) st[i] <= in_data;
            for (int k = 0; k < KEY_LANES; k++)
              if (beat_idx == CW'(k)) begin
`ifdef FISHINGROD_KEY_HOLD_EN
                ky[k] <= reuse_now ? shadow[k] : in_key;
                if (!reuse_now) shadow[k] <= in_key;
`else
                ky[k] <= reuse_now ? '0 : in_key;
`endif
              end
`ifdef FISHINGROD_KEY_HOLD_EN
            if (state_q == IDLE) reuse_q <= key_reuse;
`endif
            beat_cnt <= beat_idx + CW'(1);
          end
          if (load_done) begin
            step_cnt  <= '0;
            round_cnt <= 5'd1;
          end
        end
        RUN: begin
          // Lane 0 is consumed each step; the updated lane re-enters at the tail
          for (int i = 0; i < STATE_LANES - 1; i++) st[i] <= st[i+1];
          st[STATE_LANES-1] <= lane_nxt;
          for (int k = 0; k < KEY_LANES - 1; k++) ky[k] <= ky[k+1];
          ky[KEY_LANES-1] <= key_nxt;
          if (step_cnt == LAST_LANE) begin
            step_cnt  <= '0;
            round_cnt <= round_cnt + 5'd1;
          end else begin
            step_cnt <= step_cnt + CW'(1);
          end
          if (run_last) beat_cnt <= '0;
        end
        DRAIN: begin
          if (out_ready) beat_cnt <= out_last ? '0 : beat_cnt + CW'(1);
        end
        default: beat_cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/fishingrod_serial_engine.md
Name: fishingrod_serial_engine

Overview:
- Parametrised, self-sequenced successor to the Fishingrod lane-serial round datapath.
- Contains the round datapath plus an internal FSM and step/round counters that generate all lane selects; callers no longer drive select or round inputs.
- Moves whole blocks through valid/ready streams of LANE_W-bit beats; key lanes arrive beside the data lanes.
- Sits between the host stream interface and the result FIFO in the Fishingrod parallel top.

Parameters:
- LANE_W, 8, lane width in bits; legal values 4, 8, 16.
- STATE_LANES, 12, state lanes per block.
- KEY_LANES, 8, key register lanes; must be <= STATE_LANES.
- NUM_ROUNDS, 25, round count; legal range 1..31.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine accepts the input beat.
- in_data  in  LANE_W  plaintext lane, lane 0 first.
- in_key  in  LANE_W  key lane; sampled only on beats 0..KEY_LANES-1.
- in_last  in  1  marks beat STATE_LANES-1.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_data  out  LANE_W  ciphertext lane, lane 0 first.
- out_last  out  1  marks the final output beat.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky protocol error; cleared by rst only.

Behaviour:
- Reset: asynchronous and active-high; applies immediately regardless of ck. Holds: FSM=IDLE, counters=0, state/key registers=0, in_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, err=0. Assertion mid-operation discards the block in flight with no partial output.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE: in_ready=1. On an in_valid beat, store lane 0 and go to LOAD with beat_cnt=1.
- LOAD: in_ready=1. Each handshake shifts in_data into state lane beat_cnt, and in_key into key lane beat_cnt while beat_cnt<KEY_LANES.
  - in_last on beat STATE_LANES-1: go to RUN with step=0, round=1.
  - in_last on any earlier beat, or missing on the final beat: set err, drop the block, return to IDLE.
- RUN: in_ready=0. Advances one datapath step per cycle.
  - step counts 0..STATE_LANES-1; round counts 1..NUM_ROUNDS.
  - The state S-box select is active when step=STATE_LANES-1.
  - At step 0 the round constant {zero-extend, round[4:0]} is XORed into key lane 0.
  - The key S-box update is enabled when step=KEY_LANES/2.
  - After step STATE_LANES-1 of round NUM_ROUNDS, go to DRAIN with beat_cnt=0.
  - RUN lasts exactly NUM_ROUNDS*STATE_LANES cycles.
- DRAIN: out_valid=1. out_data is state lane beat_cnt. beat_cnt advances only on out_valid&&out_ready, so out_data must hold stable while stalled. out_last is high at beat_cnt=STATE_LANES-1; the handshake on that beat returns the FSM to IDLE.
- Latency: the first out_valid comes NUM_ROUNDS*STATE_LANES+1 cycles after the in_last handshake.
- Throughput: no overlap between blocks. in_ready is low from the in_last handshake until the cycle after the out_last handshake.
- Width rule: the GF(2^LANE_W) doubling reduction polynomial comes from the package table, indexed by LANE_W; for LANE_W=8 it is 0x1B. All XORs are LANE_W wide; the round value is truncated or zero-extended to LANE_W.
- Simultaneous events: out_ready is ignored outside DRAIN. in_valid is ignored outside IDLE and LOAD.

Optional Feature:
- Macro: FISHINGROD_KEY_HOLD_EN.
- With the macro: add input key_reuse (1 bit), sampled on beat 0. When key_reuse=1, in_key is ignored and the key lanes reload from a shadow copy captured at the previous LOAD. The shadow resets to 0.
- Without the macro: key_reuse does not exist; every block loads its key from in_key.

Decomposition:
- Package fishingrod_pkg holds:
  - state_e enum (IDLE/LOAD/RUN/DRAIN);
  - reduction polynomial table per LANE_W;
  - function clog2;
  - the 4-bit S-box as a function, with 16-bit and 8-bit S-boxes built from parallel copies.
- Sub-module fishingrod_lane_step: the purely combinational one-step lane update, taking state, key, step decodes and round constant.
- The engine owns the FSM, the counters and all registers.

Test Plan:
- Single block, LANE_W=8, NUM_ROUNDS=25, plaintext 0x00..0x0B, key 0x00..0x07, out_ready=1 -> first out_valid exactly 301 cycles after in_last; 12 lanes match the team C model; out_last on beat 11.
- Backpressure: same vector, out_ready toggles 1,0,0,1 -> out_data holds while stalled, identical lane sequence, no beat skipped or duplicated.
- Protocol error: in_last on beat 5 -> err=1, FSM back in IDLE, next legal block completes correctly with err still 1.
- Mid-RUN reset: assert rst at RUN cycle 150 -> all outputs 0 in the same cycle without a clock edge; a subsequent block matches the model.
- Parameter sweep: LANE_W=4 and 16 with NUM_ROUNDS=1 and 31 -> results match the model; RUN length equals NUM_ROUNDS*12 cycles.
- FISHINGROD_KEY_HOLD_EN: block A with key K, then block B with key_reuse=1 and random in_key -> B's output equals B encrypted under K.
